// File: rtl/icb_rd_dma_ctrl_if.sv
// ============================================================================
// icb_rd_dma_ctrl_if : ICB read-command/response bus plus output word stream
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface icb_rd_dma_ctrl_if;
   logic        m_cmd_valid;
   logic        m_cmd_ready;
   logic        m_cmd_read;
   logic [31:0] m_cmd_addr;
   logic [31:0] m_cmd_wdata;
   logic [3:0]  m_cmd_wmask;
   logic        m_rsp_valid;
   logic        m_rsp_ready;
   logic [31:0] m_rsp_rdata;
   logic        m_rsp_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   modport master (
      output m_cmd_valid, m_cmd_read, m_cmd_addr, m_cmd_wdata, m_cmd_wmask,
      output m_rsp_ready, out_valid, out_data,
      input  m_cmd_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, out_ready
   );

   modport slave (
      input  m_cmd_valid, m_cmd_read, m_cmd_addr, m_cmd_wdata, m_cmd_wmask,
      input  m_rsp_ready, out_valid, out_data,
      output m_cmd_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, out_ready
   );
endinterface

`default_nettype wire

// File: rtl/icb_rd_dma_ctrl.sv
// ============================================================================
// icb_rd_dma_ctrl : ICB read DMA; issues word reads and buffers data in a FIFO
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module icb_rd_dma_ctrl #(
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [15:0]              cfg_len,
   input  logic [31:0]              base_addr,
   icb_rd_dma_ctrl_if.master        bus,
   output logic [15:0]              stat_rd,
   output logic [15:0]              rd_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] c_max_out  = CW'(MAX_OUTSTANDING);
   localparam logic [CW:0]   c_fifo_dep = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [15:0]     r_len;
   logic [15:0]     r_issued;
   logic [15:0]     r_rd_count;
   logic [31:0]     r_addr;
   logic [CW-1:0]   r_outst;
   logic [CW-1:0]   r_fcnt;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic            r_done;
   logic            r_err;
   logic [31:0]     r_mem [FIFO_DEPTH];

   logic            w_cmd_valid;
   logic            w_cmd_fire;
   logic            w_rsp_fire;
   logic            w_push;
   logic            w_pop;
   logic            w_start;
   logic            w_credit_ok;
   logic            w_busy;

   assign w_busy     = (r_state != S_IDLE);
   assign w_start    = start & (r_state == S_IDLE);
   assign w_cmd_fire = w_cmd_valid & bus.m_cmd_ready;
   assign w_rsp_fire = bus.m_rsp_valid & bus.m_rsp_ready;
   assign w_push     = w_rsp_fire & ~bus.m_rsp_err & ~r_err;
   assign w_pop      = bus.out_valid & bus.out_ready;

   // Every accepted command owns a FIFO slot, so responses can never overflow it.
   assign w_credit_ok = (r_outst < c_max_out) &&
                        (({1'b0, r_outst} + {1'b0, r_fcnt}) < c_fifo_dep);

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && (cfg_len != 16'd0))
               w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            w_cmd_valid = (r_issued < r_len) && w_credit_ok && !r_err;
            if ((r_issued == r_len) || (w_rsp_fire && bus.m_rsp_err))
               w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_outst == '0)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_len      <= 16'd0;
         r_issued   <= 16'd0;
         r_rd_count <= 16'd0;
         r_addr     <= 32'd0;
         r_outst    <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_len      <= cfg_len;
            r_addr     <= {base_addr[31:2], 2'b00};
            r_issued   <= 16'd0;
            r_rd_count <= 16'd0;
            r_done     <= (cfg_len == 16'd0);
            r_err      <= 1'b0;
         end else begin
            if (w_cmd_fire) begin
               r_issued <= r_issued + 16'd1;
               r_addr   <= r_addr + 32'd4;
            end
            if ((r_state == S_DRAIN) && (r_outst == '0))
               r_done <= 1'b1;
            if (w_rsp_fire && bus.m_rsp_err)
               r_err <= 1'b1;
            if (w_push)
               r_rd_count <= r_rd_count + 16'd1;
         end
         case ({w_cmd_fire, w_rsp_fire})
            2'b10:   r_outst <= r_outst + CW'(1);
            2'b01:   r_outst <= r_outst - CW'(1);
            default: r_outst <= r_outst;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + CW'(1);
            2'b01:   r_fcnt <= r_fcnt - CW'(1);
            default: r_fcnt <= r_fcnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= bus.m_rsp_rdata;
   end

   assign bus.m_cmd_valid = w_cmd_valid;
   assign bus.m_cmd_read  = 1'b1;
   assign bus.m_cmd_addr  = r_addr;
   assign bus.m_cmd_wdata = 32'd0;
   assign bus.m_cmd_wmask = 4'd0;
   assign bus.m_rsp_ready = (r_outst != '0);
   assign bus.out_valid   = (r_fcnt != '0);
   assign bus.out_data    = (r_fcnt != '0) ? r_mem[r_rptr] : 32'd0;

   assign stat_rd  = {13'd0, r_err, r_done, w_busy};
   assign rd_count = r_rd_count;

endmodule

`default_nettype wire

// File: tb/tb_icb_rd_dma_ctrl.sv
// ============================================================================
// tb_icb_rd_dma_ctrl : directed self-checking bench with an ICB memory model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_icb_rd_dma_ctrl;

   localparam logic [31:0] c_dmask = 32'hC0DE_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] cfg_len = 16'd0;
   logic [31:0] base_addr = 32'd0;
   logic [15:0] stat_rd;
   logic [15:0] rd_count;

   icb_rd_dma_ctrl_if bus ();

   icb_rd_dma_ctrl #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cfg_len   (cfg_len),
      .base_addr (base_addr),
      .bus       (bus),
      .stat_rd   (stat_rd),
      .rd_count  (rd_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // model configuration, written only by the main sequence
   bit stall     = 1'b0;
   int rsp_delay = 0;
   int err_idx   = -1;
   int clr_req   = 0;

   // model state, written only by the model process
   int          cyc = 0;
   int          clr_seen = 0;
   logic [31:0] pend_addr[$];
   int          pend_t[$];
   logic [31:0] cmd_log[$];
   logic [31:0] out_log[$];
   int          outst = 0;
   int          max_outst = 0;
   int          stab_viol = 0;
   int          rsp_idx = 0;
   int          cmd_after_err = 0;
   bit          err_seen = 1'b0;
   bit          prev_wait = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] get_cmd(input int i);
      return (i < cmd_log.size()) ? cmd_log[i] : 32'hBAD0_BAD0;
   endfunction

   function automatic logic [31:0] get_out(input int i);
      return (i < out_log.size()) ? out_log[i] : 32'hBAD0_BAD0;
   endfunction

   // Memory model: decisions at negedge; DUT outputs have no combinational input paths.
   initial begin
      bus.m_cmd_ready = 1'b0;
      bus.m_rsp_valid = 1'b0;
      bus.m_rsp_rdata = 32'd0;
      bus.m_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            pend_addr.delete(); pend_t.delete();
            cmd_log.delete();   out_log.delete();
            outst = 0; max_outst = 0; stab_viol = 0; rsp_idx = 0;
            cmd_after_err = 0; err_seen = 1'b0; prev_wait = 1'b0;
         end
         bus.m_cmd_ready = stall ? ((cyc % 3) == 0) : 1'b1;
         if (prev_wait && (!bus.m_cmd_valid || bus.m_cmd_addr != prev_addr))
            stab_viol++;
         if (bus.m_cmd_valid && bus.m_cmd_ready) begin
            cmd_log.push_back(bus.m_cmd_addr);
            pend_addr.push_back(bus.m_cmd_addr);
            pend_t.push_back(cyc + 1 + rsp_delay);
            outst++;
            if (err_seen) cmd_after_err++;
            prev_wait = 1'b0;
         end else begin
            prev_wait = bus.m_cmd_valid;
            prev_addr = bus.m_cmd_addr;
         end
         if (pend_addr.size() > 0 && pend_t[0] <= cyc) begin
            bus.m_rsp_valid = 1'b1;
            bus.m_rsp_rdata = pend_addr[0] ^ c_dmask;
            bus.m_rsp_err   = (rsp_idx == err_idx);
            if (bus.m_rsp_ready) begin
               if (bus.m_rsp_err) err_seen = 1'b1;
               void'(pend_addr.pop_front());
               void'(pend_t.pop_front());
               rsp_idx++;
               outst--;
            end
         end else begin
            bus.m_rsp_valid = 1'b0;
            bus.m_rsp_err   = 1'b0;
         end
         if (outst > max_outst) max_outst = outst;
         if (bus.out_valid && bus.out_ready)
            out_log.push_back(bus.out_data);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_model();
      clr_req++;
      @(negedge clk);
      #1;
      tick(1);
   endtask

   task automatic do_start(input logic [15:0] len, input logic [31:0] base);
      start = 1'b1; cfg_len = len; base_addr = base;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (!(stat_rd[1] && !stat_rd[0]) && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, 32'(k < budget), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.out_ready = 1'b0;
      tick(3);
      check("rst_stat",  32'(stat_rd), 32'h0);
      check("rst_cnt",   32'(rd_count), 32'h0);
      check("rst_cmdv",  32'(bus.m_cmd_valid), 32'h0);
      check("rst_addr",  bus.m_cmd_addr, 32'h0);
      check("rst_rspr",  32'(bus.m_rsp_ready), 32'h0);
      check("rst_outv",  32'(bus.out_valid), 32'h0);
      check("rst_outd",  bus.out_data, 32'h0);
      rst_n = 1'b1;
      tick(2);

      // basic 3-word transfer
      stall = 0; rsp_delay = 0; err_idx = -1; bus.out_ready = 1'b1;
      clear_model();
      do_start(16'd3, 32'h0000_1000);
      wait_idle("t1_done", 50);
      tick(4);
      check("t1_ncmd", 32'(cmd_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("t1_addr", get_cmd(i), 32'h1000 + 32'(4 * i));
         check("t1_data", get_out(i), (32'h1000 + 32'(4 * i)) ^ c_dmask);
      end
      check("t1_nout", 32'(out_log.size()), 32'd3);
      check("t1_stat", 32'(stat_rd), 32'h2);
      check("t1_cnt",  32'(rd_count), 32'd3);

      // back-pressure: FIFO fills to 4, issue stalls
      bus.out_ready = 1'b0;
      clear_model();
      do_start(16'd8, 32'h0000_2000);
      tick(30);
      check("t2_cnt4",  32'(rd_count), 32'd4);
      check("t2_busy",  32'(stat_rd), 32'h1);
      check("t2_outv",  32'(bus.out_valid), 32'd1);
      check("t2_ncmd4", 32'(cmd_log.size()), 32'd4);
      check("t2_head",  bus.out_data, 32'h2000 ^ c_dmask);
      bus.out_ready = 1'b1;
      wait_idle("t2_done", 100);
      tick(6);
      check("t2_cnt8", 32'(rd_count), 32'd8);
      check("t2_stat", 32'(stat_rd), 32'h2);
      check("t2_nout", 32'(out_log.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         check("t2_data", get_out(i), (32'h2000 + 32'(4 * i)) ^ c_dmask);

      // slow responses and stalled command ready
      stall = 1; rsp_delay = 5;
      clear_model();
      do_start(16'd4, 32'h0000_3000);
      wait_idle("t3_done", 200);
      tick(6);
      check("t3_maxout", 32'(max_outst), 32'd2);
      check("t3_stable", 32'(stab_viol), 32'd0);
      check("t3_ncmd",   32'(cmd_log.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check("t3_addr", get_cmd(i), 32'h3000 + 32'(4 * i));
      check("t3_cnt",    32'(rd_count), 32'd4);
      check("t3_nout",   32'(out_log.size()), 32'd4);

      // error on the second response
      stall = 0; rsp_delay = 3; err_idx = 1; bus.out_ready = 1'b0;
      clear_model();
      do_start(16'd5, 32'h0000_4000);
      wait_idle("t4_done", 200);
      tick(2);
      check("t4_stat",    32'(stat_rd), 32'h6);
      check("t4_cnt",     32'(rd_count), 32'd1);
      check("t4_ncmd",    32'(cmd_log.size()), 32'd3);
      check("t4_after",   32'(cmd_after_err), 32'd0);
      check("t4_drained", 32'(pend_addr.size()), 32'd0);
      check("t4_outv",    32'(bus.out_valid), 32'd1);
      check("t4_head",    bus.out_data, 32'h4000 ^ c_dmask);
      bus.out_ready = 1'b1;
      tick(3);
      check("t4_empty",   32'(bus.out_valid), 32'd0);
      check("t4_nout",    32'(out_log.size()), 32'd1);

      // zero length, ignored start while busy, address wrap
      rsp_delay = 0; err_idx = -1;
      clear_model();
      do_start(16'd0, 32'h5555_5554);
      check("t5_len0_stat", 32'(stat_rd), 32'h2);
      tick(5);
      check("t5_len0_ncmd", 32'(cmd_log.size()), 32'd0);
      start = 1'b1; cfg_len = 16'd2; base_addr = 32'hFFFF_FFFC;
      tick(1);
      cfg_len = 16'd7; base_addr = 32'h0000_5000;
      tick(1);
      start = 1'b0;
      wait_idle("t5_done", 50);
      tick(4);
      check("t5_ncmd",  32'(cmd_log.size()), 32'd2);
      check("t5_addr0", get_cmd(0), 32'hFFFF_FFFC);
      check("t5_addr1", get_cmd(1), 32'h0000_0000);
      check("t5_cnt",   32'(rd_count), 32'd2);
      check("t5_data1", get_out(1), 32'h0000_0000 ^ c_dmask);

      // asynchronous reset with two commands in flight
      rsp_delay = 10;
      clear_model();
      do_start(16'd4, 32'h0000_6000);
      begin
         int k = 0;
         while (outst != 2 && k < 20) begin
            tick(1);
            k++;
         end
         check("t6_reach2", 32'(outst), 32'd2);
      end
      rst_n = 1'b0;
      #1;
      check("t6_cmdv", 32'(bus.m_cmd_valid), 32'd0);
      check("t6_addr", bus.m_cmd_addr, 32'd0);
      check("t6_rspr", 32'(bus.m_rsp_ready), 32'd0);
      check("t6_outv", 32'(bus.out_valid), 32'd0);
      check("t6_outd", bus.out_data, 32'd0);
      check("t6_stat", 32'(stat_rd), 32'd0);
      check("t6_cnt",  32'(rd_count), 32'd0);
      clear_model();
      rst_n = 1'b1;
      tick(15);
      check("t6_nocmd", 32'(cmd_log.size()), 32'd0);
      check("t6_idle",  32'(stat_rd), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/icb_rd_dma_ctrl.md
ICB_RD_DMA_CTRL -- requirements
Module: icb_rd_dma_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- FIFO_DEPTH, 4, output data buffer entries (power of 2, >=2).
- MAX_OUTSTANDING, 2, max ICB read commands accepted but not yet responded (<= FIFO_DEPTH).
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle launch pulse (driven from STAT_REG_WR[0]).
- cfg_len  in  16  transfer length in 32-bit words (from CONFIG_REG[15:0]).
- base_addr  in  32  first read byte address (from BASERDADDR_REG).
- m_cmd_valid  out  1  ICB master command valid.
- m_cmd_ready  in  1  ICB master command ready.
- m_cmd_read  out  1  constant 1.
- m_cmd_addr  out  32  command address.
- m_cmd_wdata  out  32  constant 0.
- m_cmd_wmask  out  4  constant 0.
- m_rsp_valid  in  1  ICB response valid.
- m_rsp_ready  out  1  ICB response ready.
- m_rsp_rdata  in  32  response data.
- m_rsp_err  in  1  response error.
- out_valid  out  1  stream data valid (FIFO not empty).
- out_ready  in  1  stream consumer ready.
- out_data  out  32  stream data (FIFO head).
- stat_rd  out  16  {13'b0, err, done, busy}; feeds STAT_REG_RD.
- rd_count  out  16  words pushed into FIFO in current/last transfer.

Function
REQ-003 States IDLE, ISSUE, DRAIN; busy SHALL be 1 exactly in ISSUE and DRAIN.
REQ-004 IDLE + start: latch cfg_len, {base_addr[31:2],2'b00}; clear done, err, rd_count, issue count; go ISSUE next cycle.
REQ-005 start while busy SHALL be ignored; latched values unchanged.
REQ-006 start with cfg_len==0: no commands; done=1 on the cycle after start; state stays IDLE.
REQ-007 ISSUE: m_cmd_valid=1 when issued<len AND outstanding<MAX_OUTSTANDING AND outstanding+fifo_count<FIFO_DEPTH; no error seen.
REQ-008 Once m_cmd_valid rises, it and m_cmd_addr SHALL hold stable until m_cmd_ready.
REQ-009 Command accepted (valid&ready): issued+1, address+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000), outstanding+1.
REQ-010 ISSUE -> DRAIN when issued==len, or on first error response.
REQ-011 DRAIN -> IDLE when outstanding==0; on that transition done=1 (sticky until next accepted start).
REQ-012 m_rsp_ready SHALL be 1 whenever outstanding>0 (space reserved by REQ-007 credit rule), else 0.
REQ-013 Response accepted: outstanding-1; if m_rsp_err=0 and no prior error push m_rsp_rdata into FIFO and rd_count+1, else discard data.
REQ-014 m_rsp_err=1 on any accepted response SHALL set err=1 (sticky until next accepted start); remaining outstanding responses drained and discarded.
REQ-015 Simultaneous cmd accept and rsp accept: outstanding unchanged.
REQ-016 FIFO: push per REQ-013, pop on out_valid&out_ready; simultaneous push/pop SHALL keep count; FIFO never overflows; data order preserved; read/write pointers wrap modulo FIFO_DEPTH.
REQ-017 FIFO contents SHALL persist after return to IDLE until popped; a new start does not flush the FIFO.
REQ-018 Response arriving with outstanding==0 is a protocol violation; not accepted (m_rsp_ready=0).

Reset
REQ-019 rst_n low: state IDLE, m_cmd_valid=0, m_cmd_addr=0, m_rsp_ready=0, out_valid=0, out_data=0, stat_rd=0, rd_count=0, FIFO empty, counters 0, effective immediately, including mid-transfer.
REQ-020 After rst_n release, no command issued until a new start.

Verification
REQ-021 len=3, base=0x1000, cmd_ready/rsp always 1, out_ready=1 -> addresses 0x1000,0x1004,0x1008; 3 words out in order; done=1, rd_count=3, stat_rd=0x0002.
REQ-022 len=8, out_ready=0 -> exactly 4 words buffered, issue stalls, out_valid=1; then out_ready=1 -> remaining 4 read; rd_count=8, done.
REQ-023 len=4, responses delayed 5 cycles -> never more than 2 outstanding; m_cmd_addr stable while cmd_ready=0.
REQ-024 len=5, m_rsp_err=1 on 2nd response -> no new commands after error; 1 word in FIFO; stat_rd=0x0006.
REQ-025 start with len=0 -> no m_cmd_valid, stat_rd=0x0002 next cycle; start during busy ignored; base=0xFFFFFFFC len=2 -> addresses 0xFFFFFFFC, 0x00000000.
REQ-026 rst_n asserted mid-transfer with 2 outstanding -> all outputs at reset values same cycle; no commands after release.
